if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-high.
REQ-005 rdy_in  input  1  global enable; when low, all internal state and registered outputs SHALL hold.
REQ-006 mc_re  output  1  read request to the memory controller fetch port; one-cycle pulse.
REQ-007 mc_addr  output  32  byte address of the requested word.
REQ-008 mc_len  output  3  access length in bytes; constant 3'd4.
REQ-009 mc_busy  input  1  memory controller fetch port busy.
REQ-010 mc_done  input  1  one-cycle pulse: read complete, mc_r_data valid this cycle.
REQ-011 mc_r_data  input  32  little-endian instruction word.
REQ-012 inst_valid  output  1  queue head holds a valid instruction.
REQ-013 inst  output  32  queue-head instruction word.
REQ-014 inst_pc  output  32  queue-head address.
REQ-015 inst_ready  input  1  consumer pops the head when inst_valid&inst_ready.
REQ-016 flush  input  1  redirect fetch (branch/jump); single-cycle pulse.
REQ-017 flush_pc  input  32  new fetch address, sampled when flush=1.

Function
REQ-018 The block SHALL hold a FIFO of DEPTH {pc,inst} entries with a count register of width clog2(DEPTH)+1.
REQ-019 The FSM SHALL have three states: IDLE, WAIT (one read outstanding), DROP (outstanding read to be discarded).
REQ-020 IDLE: if count<DEPTH and mc_busy=0 and flush=0, set mc_re<=1 and mc_addr<=fetch_pc for one cycle, then go to WAIT.
REQ-021 WAIT: mc_re<=0; on mc_done push {fetch_pc, mc_r_data}, set fetch_pc<=fetch_pc+4 (mod 2^32), then go to IDLE.
REQ-022 At most one read SHALL be outstanding; a new request is never issued in the cycle mc_done arrives.
REQ-023 Head outputs SHALL be combinational from the FIFO read pointer; inst_valid = (count!=0).
REQ-024 Pop and push in the same cycle SHALL leave count unchanged; pop when empty and push when full SHALL not occur by construction.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 flush SHALL have priority over all other events: clear count and pointers, set fetch_pc<=flush_pc, and ignore any simultaneous pop.
REQ-027 flush in WAIT without mc_done SHALL go to DROP; DROP discards the next mc_done data and returns to IDLE.
REQ-028 flush coinciding with mc_done in WAIT SHALL discard the data and go to IDLE.
REQ-029 flush in DROP SHALL update fetch_pc and remain in DROP.
REQ-030 flush in IDLE SHALL suppress the request that cycle; the request for flush_pc issues no earlier than the next cycle.
REQ-031 Steady-state throughput SHALL be one instruction per memory access plus one IDLE cycle.

Reset
REQ-032 While rst_in=1: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, mc_re=0, mc_addr=0, inst_valid=0.
REQ-033 Reset asserted mid-access SHALL abandon the access; an mc_done arriving after reset release SHALL be ignored only if it arrives in IDLE.

Verification
REQ-034 Reset release, memory model returns mc_done 5 cycles after mc_re -> mc_re pulses with mc_addr 0,4,8,12; inst_pc sequence 0,4,8,12 with matching words.
REQ-035 inst_ready=0, DEPTH=4 -> exactly four requests issued, then mc_re stays 0 while count=4; a single pop triggers one request to address 16.
REQ-036 flush with flush_pc=32'h100 two cycles after mc_re for 0x8 -> inst_valid drops next cycle; late data for 0x8 is never visible; next mc_addr=0x100.
REQ-037 flush coincident with mc_done -> returned word discarded, count=0, next request to flush_pc.
REQ-038 rdy_in held low 3 cycles during WAIT -> no state, pointer, or output change; the sequence resumes identically afterward.
REQ-039 Push and pop in the same cycle at count=2 -> count stays 2 and head advances by one entry.

Source files
------------

// File: rtl/if_prefetch.sv
`timescale 1ns/1ps
// if_prefetch
// Instruction prefetch unit. Issues word reads to the memory-controller fetch
// port one at a time, collects returned words with their addresses in a small
// FIFO, and presents the oldest entry to the decode stage. A flush redirects
// fetching and empties the queue. A read that was in flight when the flush
// arrived is allowed to finish, but its data is thrown away.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                global enable; low freezes every register
//   mc_re/mc_addr/mc_len  read request (one-cycle pulse, byte address, 4 bytes)
//   mc_busy               fetch port busy, no request may issue
//   mc_done/mc_r_data     read completion pulse and returned word
//   inst_valid/inst/inst_pc  queue head (combinational from the read pointer)
//   inst_ready            consumer pops the head when inst_valid is high
//   flush/flush_pc        redirect fetch to flush_pc and clear the queue
module if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mc_re,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  input  logic        mc_busy,
  input  logic        mc_done,
  input  logic [31:0] mc_r_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;

  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] fifo_inst [DEPTH];

  logic push;
  logic pop;
  logic full;

  // A flush cancels both the pop and any push of the word arriving with it.
  assign push = (state == WAIT) && mc_done && !flush;
  assign pop  = inst_valid && inst_ready && !flush;
  assign full = (count == CW'(DEPTH));

  assign mc_len     = 3'd4;
  assign inst_valid = (count != '0);
  assign inst       = fifo_inst[rptr];
  assign inst_pc    = fifo_pc[rptr];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
      mc_re    <= 1'b0;
      mc_addr  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        count    <= '0;
        rptr     <= '0;
        wptr     <= '0;
        fetch_pc <= flush_pc;
        mc_re    <= 1'b0;
        // An outstanding read must still be drained; if it completes in this
        // very cycle nothing remains in flight and fetching can restart.
        case (state)
          IDLE:       state <= IDLE;
          WAIT, DROP: state <= mc_done ? IDLE : DROP;
          default:    state <= IDLE;
        endcase
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);

        case (state)
          IDLE: begin
            if (!full && !mc_busy) begin
              mc_re   <= 1'b1;
              mc_addr <= fetch_pc;
              state   <= WAIT;
            end else begin
              mc_re <= 1'b0;
            end
          end
          WAIT: begin
            mc_re <= 1'b0;
            if (mc_done) begin
              fetch_pc <= fetch_pc + 32'd4;
              state    <= IDLE;
            end
          end
          DROP: begin
            mc_re <= 1'b0;
            if (mc_done) state <= IDLE;
          end
          default: begin
            mc_re <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Queue storage carries data only, so it has no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && push) begin
      fifo_pc[wptr]   <= fetch_pc;
      fifo_inst[wptr] <= mc_r_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
`timescale 1ns/1ps
// tb_if_prefetch
// Bench for if_prefetch with a 5-cycle-latency memory model and a queue of
// expected {pc, word} entries that is compared whenever the consumer pops.
module tb_if_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          LAT      = 5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        mc_re;
  logic [31:0] mc_addr;
  logic [2:0]  mc_len;
  logic        mc_busy = 1'b0;
  logic        mc_done = 1'b0;
  logic [31:0] mc_r_data = 32'hDEAD_BEEF;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mc_re(mc_re), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_r_data(mc_r_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  typedef struct {
    logic [31:0] addr;  // expected mc_addr of the i-th request
    logic [31:0] word;  // expected instruction word for that address
  } vec_t;

  ent_t        exp_q[$];
  vec_t        tbl[4];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cd = 0;
  int          req_cnt = 0;
  int          cyc = 0;
  bit          drop_pending = 1'b0;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] req_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs at a falling edge with this cycle's inputs already set: checks the
  // head against the expected queue, drives the memory response, and
  // captures any new request.
  task automatic run_models();
    ent_t e;
    check("valid_vs_model", inst_valid, exp_q.size() != 0);
    if (inst_valid && inst_ready && rdy_in && !flush && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("head_pc", inst_pc, e.pc);
      check("head_inst", inst, e.word);
    end
    mc_done   = 1'b0;
    mc_r_data = 32'hDEAD_BEEF;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mc_done   = 1'b1;
        mc_r_data = mem_word(req_addr);
        if (flush || drop_pending) drop_pending = 1'b0;
        else exp_q.push_back('{pc: req_addr, word: mem_word(req_addr)});
      end
    end
    if (mc_re) begin
      check("req_addr", mc_addr, exp_addr);
      check("one_outstanding", cd, 0);
      req_addr = mc_addr;
      exp_addr = exp_addr + 32'd4;
      cd = LAT;
      req_cnt++;
    end
    if (flush) begin
      exp_q.delete();
      exp_addr = flush_pc;
      if (cd > 0) drop_pending = 1'b1;
    end
  endtask

  task automatic step();
    run_models();
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic wait_re();
    int k;
    k = 0;
    while (!mc_re && k < 60) begin
      step();
      k++;
    end
    check("req_seen", mc_re, 1'b1);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!inst_valid && k < 60) begin
      step();
      k++;
    end
    check("valid_seen", inst_valid, 1'b1);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    flush = 1'b0;
    inst_ready = 1'b0;
    mc_done = 1'b0;
    cd = 0;
    drop_pending = 1'b0;
    exp_q.delete();
    exp_addr = RESET_PC;
    req_cnt = 0;
    #1;
    check("rst_mc_re", mc_re, 1'b0);
    check("rst_mc_addr", mc_addr, 32'h0);
    check("rst_valid", inst_valid, 1'b0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t1;
    int k;
    int n0;
    tbl[0] = '{addr: 32'h0,  word: mem_word(32'h0)};
    tbl[1] = '{addr: 32'h4,  word: mem_word(32'h4)};
    tbl[2] = '{addr: 32'h8,  word: mem_word(32'h8)};
    tbl[3] = '{addr: 32'hC,  word: mem_word(32'hC)};

    @(negedge clk_in);
    do_reset();
    check("mc_len", mc_len, 3'd4);

    // Four sequential fetches fill the queue with no consumer.
    for (int i = 0; i < 4; i++) begin
      wait_re();
      check("seq_addr", mc_addr, tbl[i].addr);
      step();
    end
    repeat (25) step();
    check("full_req_cnt", req_cnt, 4);
    check("full_no_req", mc_re, 1'b0);

    // One pop frees a slot and releases exactly one request, to 16.
    check("head0_pc", inst_pc, tbl[0].addr);
    check("head0_inst", inst, tbl[0].word);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    wait_re();
    check("refill_addr", mc_addr, 32'h10);
    step();
    check("refill_cnt", req_cnt, 5);
    for (int i = 1; i < 4; i++) begin
      check("head_tbl_pc", inst_pc, tbl[i].addr);
      check("head_tbl_inst", inst, tbl[i].word);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
    end

    // Flush two cycles after the request for 0x8.
    do_reset();
    k = 0;
    while (!(mc_re && mc_addr == 32'h8) && k < 60) begin
      step();
      k++;
    end
    check("req8_seen", mc_addr, 32'h8);
    step();
    step();
    flush = 1'b1;
    flush_pc = 32'h100;
    step();
    flush = 1'b0;
    check("flush_clears_valid", inst_valid, 1'b0);
    wait_re();
    check("flush_redirect_addr", mc_addr, 32'h100);
    wait_valid();
    check("flush_head_pc", inst_pc, 32'h100);
    check("flush_head_inst", inst, mem_word(32'h100));

    // Flush in the same cycle as mc_done.
    wait_re();
    step();
    repeat (4) step();
    flush = 1'b1;
    flush_pc = 32'h200;
    step();
    flush = 1'b0;
    check("done_flush_valid", inst_valid, 1'b0);
    wait_re();
    check("done_flush_addr", mc_addr, 32'h200);

    // rdy_in low for three cycles in WAIT, with a pop requested meanwhile.
    wait_valid();
    wait_re();
    check("stall_req_addr", mc_addr, 32'h204);
    step();
    rdy_in = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_mc_re", mc_re, 1'b0);
      check("stall_mc_addr", mc_addr, 32'h204);
      check("stall_valid", inst_valid, 1'b1);
      check("stall_head_pc", inst_pc, 32'h200);
    end
    rdy_in = 1'b1;
    inst_ready = 1'b0;
    wait_re();
    check("resume_addr", mc_addr, 32'h208);

    // Reset in the middle of an access abandons it.
    step();
    step();
    do_reset();
    wait_re();
    check("post_reset_addr", mc_addr, RESET_PC);

    // Push and pop together at count 2.
    k = 0;
    while (!(exp_q.size() == 2 && cd == 1) && k < 60) begin
      step();
      k++;
    end
    check("pp_setup_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();
    check("pp_head_adv", inst_pc, 32'h4);
    check("pp_valid", inst_valid, 1'b1);
    step();
    check("pp_head2", inst_pc, 32'h8);
    step();
    inst_ready = 1'b0;
    check("pp_count2_drained", inst_valid, 1'b0);

    // No request while the fetch port reports busy.
    wait_re();
    step();
    mc_busy = 1'b1;
    n0 = req_cnt;
    repeat (15) step();
    check("busy_no_req", req_cnt, n0);
    mc_busy = 1'b0;
    wait_re();

    // Steady-state spacing: one access plus one IDLE cycle.
    inst_ready = 1'b1;
    step();
    t1 = cyc - 1;
    wait_re();
    check("throughput_gap", cyc - t1, LAT + 2);
    step();
    inst_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
